// File: rtl/riscv_pkg.sv
// Shared decode-stage types and helpers for the hazard scoreboard.
// Holds the latency-class encoding, register-file geometry and the per-class
// latency lookup used when an instruction issues.
package riscv_pkg;

  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_MDU  = 2'd2
  } lat_class_t;

  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  // Cycles a dependent instruction must wait after an op of class c issues.
  function automatic int unsigned lat_of(input lat_class_t c,
                                         input int unsigned load_lat,
                                         input int unsigned mdu_lat);
    case (c)
      LAT_LOAD: return load_lat;
      LAT_MDU:  return mdu_lat;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Scoreboard down-counter: counts remaining cycles until a result is forwardable.
// Ports: clk/rst_n (async active-low), i_load/i_load_val (set value),
//        o_cnt (current count), o_nz (count is nonzero).
// A load in the same cycle wins over the decrement; the count saturates at 0.
module sb_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic [CW-1:0] o_cnt,
  output logic          o_nz
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_nz  = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: stalls IF/ID (and bubbles ID/EX) until every
// source of the ID instruction is forwardable, WAW ordering is safe and the MDU is free.
// Ports: clk, rst_n (async active-low); ID instruction fields valid_ID, readReg1/2,
//        useRs1/2, regWrite_ID, writeReg_ID, latClass_ID; flush from EX.
//        Outputs: stall (combinational), mdu_busy, pending (per-register nonzero count).
module hazard_scoreboard
  import riscv_pkg::*;
#(
  parameter int NUM_REGS = riscv_pkg::NUM_REGS,
  parameter int LOAD_LAT = 1,
  parameter int MDU_LAT  = 4,
  parameter int CW       = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_ID,
  input  logic [4:0]          readReg1,
  input  logic [4:0]          readReg2,
  input  logic                useRs1,
  input  logic                useRs2,
  input  logic                regWrite_ID,
  input  logic [4:0]          writeReg_ID,
  input  logic [1:0]          latClass_ID,
  input  logic                flush,
  output logic                stall,
  output logic                mdu_busy,
  output logic [NUM_REGS-1:0] pending
);

  logic [CW-1:0]       w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_nz;
  lat_class_t          w_cls;
  logic [CW-1:0]       w_lat;
  logic [CW-1:0]       w_mdu_cnt;
  logic                w_mdu_nz;
  logic                w_raw;
  logic                w_waw;
  logic                w_struct;
  logic                w_live;
  logic                w_issue;
  logic                w_issue_wr;

  // Encoding 3 is unused and behaves as a plain ALU op.
  assign w_cls = (latClass_ID == 2'd3) ? LAT_ALU : lat_class_t'(latClass_ID);
  assign w_lat = CW'(lat_of(w_cls, LOAD_LAT, MDU_LAT));

  // x0 is hardwired zero: no counter, never pending.
  assign w_cnt[0] = '0;
  assign w_nz[0]  = 1'b0;

  genvar g;
  for (g = 1; g < NUM_REGS; g++) begin : g_reg
    sb_counter #(.CW(CW)) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_load     (w_issue_wr && (writeReg_ID == REG_AW'(g))),
      .i_load_val (w_lat),
      .o_cnt      (w_cnt[g]),
      .o_nz       (w_nz[g])
    );
  end

  // Single non-pipelined MDU: any MDU op holds it for MDU_LAT cycles.
  sb_counter #(.CW(CW)) u_mdu_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_issue && (w_cls == LAT_MDU)),
    .i_load_val (CW'(MDU_LAT)),
    .o_cnt      (w_mdu_cnt),
    .o_nz       (w_mdu_nz)
  );

  // Sources look at state before this instruction's own write, so rs==rd never self-blocks.
  assign w_raw = (useRs1 && (readReg1 != '0) && w_nz[readReg1]) ||
                 (useRs2 && (readReg2 != '0) && w_nz[readReg2]);

  // A younger write may only land once it cannot complete before the older one.
  assign w_waw = regWrite_ID && (writeReg_ID != '0) && (w_cnt[writeReg_ID] > w_lat);

  assign w_struct = (w_cls == LAT_MDU) && w_mdu_nz;

  // Flush kills the ID instruction outright; it neither stalls nor issues.
  assign w_live     = valid_ID && !flush;
  assign stall      = w_live && (w_raw || w_waw || w_struct);
  assign w_issue    = w_live && !stall;
  assign w_issue_wr = w_issue && regWrite_ID && (writeReg_ID != '0);

  assign mdu_busy = w_mdu_nz;
  assign pending  = w_nz;

endmodule
